// File: rtl/load_store_unit.sv
// Load/store unit: maps byte-addressed RISC-V loads/stores onto a word-addressed data memory.
// Define LSU_MISALIGN_SPLIT_EN to perform misaligned accesses (split across two words when needed).
module load_store_unit #(
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic [4:0]        resp_rd,
   output logic              resp_store,
   output logic              resp_err,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
   state_t state, state_nx;

   logic              store_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [MEM_AW-1:0] word_q;
   logic [31:0]       wdata_q;
   logic [4:0]        rd_q;
   logic              split_q;
   logic [31:0]       lo_q;
   logic              err_q;
   logic [31:0]       rdata_q;

   function automatic logic [3:0] base_be(input logic [1:0] size);
      case (size)
         2'd0:    base_be = 4'b0001;
         2'd1:    base_be = 4'b0011;
         default: base_be = 4'b1111;
      endcase
   endfunction

   // Bytes of {hi,lo} starting at byte offset off.
   function automatic logic [31:0] extract(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [1:0] off);
      case (off)
         2'd0:    extract = lo;
         2'd1:    extract = {hi[7:0],  lo[31:8]};
         2'd2:    extract = {hi[15:0], lo[31:16]};
         default: extract = {hi[23:0], lo[31:24]};
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      sb = raw[7:0];
      sh = raw[15:0];
      case (f3)
         3'd0:    extend = 32'(sb);
         3'd1:    extend = 32'(sh);
         3'd4:    extend = {24'd0, raw[7:0]};
         3'd5:    extend = {16'd0, raw[15:0]};
         default: extend = raw;
      endcase
   endfunction

   // Request decode, evaluated on the raw request at capture
   logic [2:0] req_bytes;
   logic       req_cross, f3_err, range_err, misalign_err, req_err, req_split;

   always_comb begin
      case (req_funct3[1:0])
         2'd0:    req_bytes = 3'd1;
         2'd1:    req_bytes = 3'd2;
         default: req_bytes = 3'd4;
      endcase
      req_cross = ({1'b0, req_addr[1:0]} + req_bytes) > 3'd4;
      f3_err    = req_store ? (req_funct3 > 3'd2)
                            : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
      range_err = |req_addr[31:MEM_AW+2];
`ifdef LSU_MISALIGN_SPLIT_EN
      misalign_err = req_cross && (&req_addr[MEM_AW+1:2]);
      req_split    = req_cross;
`else
      misalign_err = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
      req_split    = 1'b0;
`endif
      req_err = f3_err || range_err || misalign_err;
   end

   // Lanes and data for both possible words; the upper half belongs to word A+1
   logic [7:0]  be8;
   logic [63:0] wd64;
   assign be8  = {4'b0000, base_be(f3_q[1:0])} << off_q;
   assign wd64 = {32'd0, wdata_q} << {off_q, 3'b000};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (req_valid) state_nx = req_err ? RESP : ACC0;
         ACC0: if (mem_ready) state_nx = split_q ? ACC1 : RESP;
         ACC1: if (mem_ready) state_nx = RESP;
         RESP: if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req_valid) begin
            err_q   <= req_err;
            rdata_q <= 32'd0;
         end else if (state == ACC0 && mem_ready && !split_q && !store_q) begin
            rdata_q <= extend(extract(32'd0, mem_rdata, off_q), f3_q);
         end else if (state == ACC1 && mem_ready && !store_q) begin
            rdata_q <= extend(extract(mem_rdata, lo_q, off_q), f3_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         store_q <= req_store;
         f3_q    <= req_funct3;
         off_q   <= req_addr[1:0];
         word_q  <= req_addr[MEM_AW+1:2];
         wdata_q <= req_wdata;
         rd_q    <= req_rd;
         split_q <= req_split;
      end
      if (state == ACC0 && mem_ready) lo_q <= mem_rdata;
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign resp_rd    = rd_q;
   assign resp_store = store_q;

   assign mem_valid = (state == ACC0) || (state == ACC1);
   assign mem_we    = mem_valid && store_q;
   assign mem_be    = (state == ACC0) ? be8[3:0] : (state == ACC1) ? be8[7:4] : 4'b0000;
   assign mem_addr  = (state == ACC1) ? word_q + MEM_AW'(1) : word_q;
   assign mem_wdata = (state == ACC1) ? wd64[63:32] : wd64[31:0];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
   localparam int MEM_AW = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_store = 1'b0;
   logic [2:0]        req_funct3 = 3'd0;
   logic [31:0]       req_addr = 32'd0;
   logic [31:0]       req_wdata = 32'd0;
   logic [4:0]        req_rd = 5'd0;
   logic              resp_valid;
   logic              resp_ready = 1'b1;
   logic [31:0]       resp_rdata;
   logic [4:0]        resp_rd;
   logic              resp_store;
   logic              resp_err;
   logic              mem_valid;
   logic              mem_ready;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic              mem_rdy = 1'b1;
   logic              pl_en = 1'b0;
   logic [MEM_AW-1:0] pl_addr = '0;
   logic [31:0]       pl_data = 32'd0;
   logic [31:0]       mem [0:(1<<MEM_AW)-1];
   int                tx_total = 0;
   int                mv_total = 0;
   logic [MEM_AW-1:0] log_addr [0:255];
   logic [3:0]        log_be   [0:255];
   logic [31:0]       log_wd   [0:255];
   logic              log_we   [0:255];

   int checks = 0;
   int failures = 0;

   load_store_unit #(.MEM_AW(MEM_AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_rd(resp_rd), .resp_store(resp_store), .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_ready = mem_rdy;
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_valid && mem_ready && mem_we)
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_valid) mv_total <= mv_total + 1;
      if (mem_valid && mem_ready) begin
         log_addr[tx_total % 256] <= mem_addr;
         log_be[tx_total % 256]   <= mem_be;
         log_wd[tx_total % 256]   <= mem_wdata;
         log_we[tx_total % 256]   <= mem_we;
         tx_total <= tx_total + 1;
      end
   end

   task automatic preload(input logic [MEM_AW-1:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Present one request from IDLE; returns cycles from accept until resp_valid.
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, output int lat);
      req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic finish_resp();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_valid got=%b exp=0", mem_valid); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
      checks++; if (mem_be !== 4'b0000) begin failures++; $display("FAIL rst_mem_be got=%b exp=0000", mem_be); end
      checks++; if (resp_rdata !== 32'd0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_store_byte();
      int lat, base;
      preload(10'd1, 32'h0000_0000);
      base = tx_total;
      do_req(1'b1, 3'd0, 32'h0000_0006, 32'h1234_56AB, 5'd3, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL sb_latency got=%0d exp=2", lat); end
      checks++; if (resp_err !== 1'b0 || resp_store !== 1'b1 || resp_rdata !== 32'd0) begin failures++;
         $display("FAIL sb_resp got err=%b st=%b rd=%h exp err=0 st=1 rd=0", resp_err, resp_store, resp_rdata); end
      finish_resp();
      checks++; if (tx_total - base !== 1) begin failures++; $display("FAIL sb_txcount got=%0d exp=1", tx_total - base); end
      checks++; if (log_addr[base % 256] !== 10'd1 || log_be[base % 256] !== 4'b0100 || log_we[base % 256] !== 1'b1) begin failures++;
         $display("FAIL sb_txn got addr=%0d be=%b we=%b exp addr=1 be=0100 we=1", log_addr[base % 256], log_be[base % 256], log_we[base % 256]); end
      checks++; if (log_wd[base % 256][23:16] !== 8'hAB) begin failures++; $display("FAIL sb_wdata got=%h exp=ab", log_wd[base % 256][23:16]); end
      checks++; if (mem[1] !== 32'h00AB_0000) begin failures++; $display("FAIL sb_memword got=%h exp=00ab0000", mem[1]); end
   endtask

   task automatic test_load_ext();
      int lat;
      logic [2:0]  f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      logic [31:0] ad  [5] = '{32'h7, 32'h7, 32'h6, 32'h6, 32'h4};
      logic [31:0] exp_d [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_FFFF};
      preload(10'd1, 32'h80FF_FFFF);
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, f3[i], ad[i], 32'd0, 5'(i + 1), lat);
         checks++; if (resp_rdata !== exp_d[i] || resp_err !== 1'b0 || lat !== 2) begin failures++;
            $display("FAIL load_ext_%0d got data=%h err=%b lat=%0d exp data=%h err=0 lat=2", i, resp_rdata, resp_err, lat, exp_d[i]); end
         finish_resp();
      end
   endtask

   task automatic test_wait_states();
      preload(10'd1, 32'h1122_3344);
      mem_rdy = 1'b0;
      req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h4; req_rd = 5'd9; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         checks++; if (mem_valid !== 1'b1 || mem_addr !== 10'd1 || mem_be !== 4'b1111 || mem_we !== 1'b0) begin failures++;
            $display("FAIL wait_hold_c%0d got v=%b a=%0d be=%b we=%b exp v=1 a=1 be=1111 we=0", k, mem_valid, mem_addr, mem_be, mem_we); end
         @(posedge clk); #1;
      end
      mem_rdy = 1'b1;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL wait_early_resp got=%b exp=0", resp_valid); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1122_3344 || resp_rd !== 5'd9) begin failures++;
         $display("FAIL wait_resp_c5 got v=%b d=%h rd=%0d exp v=1 d=11223344 rd=9", resp_valid, resp_rdata, resp_rd); end
      finish_resp();
   endtask

   task automatic test_errors();
      int lat, base;
      base = mv_total;
      do_req(1'b0, 3'd2, 32'h0000_1000, 32'd0, 5'd4, lat);
      checks++; if (lat !== 1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin failures++;
         $display("FAIL err_range got lat=%0d err=%b d=%h exp lat=1 err=1 d=0", lat, resp_err, resp_rdata); end
      finish_resp();
      do_req(1'b0, 3'd3, 32'h0000_0004, 32'd0, 5'd4, lat);
      checks++; if (lat !== 1 || resp_err !== 1'b1) begin failures++; $display("FAIL err_ld_f3 got lat=%0d err=%b exp lat=1 err=1", lat, resp_err); end
      finish_resp();
      do_req(1'b1, 3'd3, 32'h0000_0004, 32'h5555_5555, 5'd4, lat);
      checks++; if (resp_err !== 1'b1 || resp_store !== 1'b1) begin failures++; $display("FAIL err_st_f3 got err=%b st=%b exp err=1 st=1", resp_err, resp_store); end
      finish_resp();
      do_req(1'b1, 3'd2, 32'h0000_0FFE, 32'h5555_5555, 5'd4, lat);
      checks++; if (resp_err !== 1'b1) begin failures++; $display("FAIL err_top_cross got err=%b exp=1", resp_err); end
      finish_resp();
      checks++; if (mv_total !== base) begin failures++; $display("FAIL err_no_mem got=%0d exp=0 mem_valid cycles", mv_total - base); end
   endtask

   task automatic test_store_load();
      int lat;
      do_req(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, 5'd0, lat); finish_resp();
      do_req(1'b1, 3'd1, 32'hA, 32'h0000_CAFE, 5'd0, lat); finish_resp();
      do_req(1'b0, 3'd2, 32'h8, 32'd0, 5'd7, lat);
      checks++; if (resp_rdata !== 32'hCAFE_BEEF) begin failures++; $display("FAIL sh_merge got=%h exp=cafebeef", resp_rdata); end
      finish_resp();
      do_req(1'b1, 3'd0, 32'h9, 32'h0000_0011, 5'd0, lat); finish_resp();
      do_req(1'b0, 3'd2, 32'h8, 32'd0, 5'd7, lat);
      checks++; if (resp_rdata !== 32'hCAFE_11EF) begin failures++; $display("FAIL sb_merge got=%h exp=cafe11ef", resp_rdata); end
      finish_resp();
   endtask

   task automatic test_misalign();
      int lat, base, mvb;
      preload(10'd1, 32'hBBBB_1234);
      preload(10'd2, 32'h5678_AAAA);
      base = tx_total; mvb = mv_total;
      do_req(1'b0, 3'd2, 32'h6, 32'd0, 5'd5, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
      checks++; if (lat !== 3 || resp_err !== 1'b0 || resp_rdata !== 32'hAAAA_BBBB) begin failures++;
         $display("FAIL lw_split got lat=%0d err=%b d=%h exp lat=3 err=0 d=aaaabbbb", lat, resp_err, resp_rdata); end
      finish_resp();
      checks++; if (tx_total - base !== 2 || log_be[base % 256] !== 4'b1100 || log_be[(base + 1) % 256] !== 4'b0011 ||
                    log_addr[base % 256] !== 10'd1 || log_addr[(base + 1) % 256] !== 10'd2) begin failures++;
         $display("FAIL lw_split_txns got n=%0d be0=%b be1=%b exp n=2 be0=1100 be1=0011", tx_total - base,
                  log_be[base % 256], log_be[(base + 1) % 256]); end
`else
      checks++; if (lat !== 1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin failures++;
         $display("FAIL lw_misalign got lat=%0d err=%b d=%h exp lat=1 err=1 d=0", lat, resp_err, resp_rdata); end
      finish_resp();
      checks++; if (mv_total !== mvb) begin failures++; $display("FAIL lw_misalign_mem got=%0d exp=0 mem_valid cycles", mv_total - mvb); end
`endif
      preload(10'd1, 32'h11F2_3344);
      base = tx_total;
      do_req(1'b0, 3'd1, 32'h5, 32'd0, 5'd6, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
      checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'hFFFF_F233) begin failures++;
         $display("FAIL lh_off1 got err=%b d=%h exp err=0 d=fffff233", resp_err, resp_rdata); end
      finish_resp();
      checks++; if (tx_total - base !== 1 || log_be[base % 256] !== 4'b0110) begin failures++;
         $display("FAIL lh_off1_be got n=%0d be=%b exp n=1 be=0110", tx_total - base, log_be[base % 256]); end
`else
      checks++; if (resp_err !== 1'b1 || tx_total !== base) begin failures++;
         $display("FAIL lh_odd got err=%b n=%0d exp err=1 n=0", resp_err, tx_total - base); end
      finish_resp();
`endif
   endtask

   task automatic test_resp_hold();
      int lat;
      preload(10'd1, 32'h0BAD_F00D);
      resp_ready = 1'b0;
      do_req(1'b0, 3'd2, 32'h4, 32'd0, 5'd12, lat);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BAD_F00D || resp_rd !== 5'd12 || req_ready !== 1'b0) begin failures++;
            $display("FAIL resp_hold_%0d got v=%b d=%h rd=%0d rdy=%b exp v=1 d=0badf00d rd=12 rdy=0", k, resp_valid, resp_rdata, resp_rd, req_ready); end
      end
      resp_ready = 1'b1;
      finish_resp();
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++;
         $display("FAIL resp_release got rdy=%b v=%b exp rdy=1 v=0", req_ready, resp_valid); end
   endtask

   task automatic test_reset_mid();
      int lat;
      preload(10'd1, 32'hCAFE_0001);
      mem_rdy = 1'b0;
      req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h4; req_rd = 5'd2; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL rstmid_acc0 got=%b exp=1", mem_valid); end
      rst = 1'b1;
      #1;
      checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++;
         $display("FAIL rstmid_abort got mv=%b rdy=%b rv=%b exp mv=0 rdy=1 rv=0", mem_valid, req_ready, resp_valid); end
      #1 rst = 1'b0;
      mem_rdy = 1'b1;
      @(posedge clk); #1;
      do_req(1'b0, 3'd2, 32'h4, 32'd0, 5'd8, lat);
      checks++; if (lat !== 2 || resp_rdata !== 32'hCAFE_0001 || resp_rd !== 5'd8 || resp_err !== 1'b0) begin failures++;
         $display("FAIL rstmid_next got lat=%0d d=%h rd=%0d err=%b exp lat=2 d=cafe0001 rd=8 err=0", lat, resp_rdata, resp_rd, resp_err); end
      finish_resp();
   endtask

   initial begin
      test_reset();
      test_store_byte();
      test_load_ext();
      test_wait_states();
      test_errors();
      test_store_load();
      test_misalign();
      test_resp_hold();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
